// File: rtl/fpa_param_if.sv
// Handshake and operand bus for the parametrised floating-point adder.
// The master drives the operands and the go pulse; the slave returns the
// status and the result.
interface fpa_param_if #(
   parameter int EXP_W = 3,
   parameter int MAN_W = 4
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         go;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         ovf;
   logic         unf;

   modport master (output go, sub, a, b, input busy, done, sum, ovf, unf);
   modport slave  (input go, sub, a, b, output busy, done, sum, ovf, unf);
endinterface

// File: rtl/fpa_param.sv
// Sequential floating-point adder/subtractor with generic exponent and
// mantissa widths.
// The operands are aligned one bit per cycle. One cycle adds or subtracts
// the significands. The result is then normalised one bit per cycle.
// Overflow saturates the result and underflow flushes it to +0.
module fpa_param #(
   parameter int EXP_W = 3,
   parameter int MAN_W = 4
) (
   input  logic         clk,
   input  logic         clr,
   fpa_param_if.slave   bus
);
   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int SIG_W = MAN_W + 2;

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t             state_q, state_d;
   logic               sign_q, sign_d;
   logic               eff_sub_q, eff_sub_d;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic [EXP_W-1:0]   d_q, d_d;
   logic [SIG_W-1:0]   x_q, x_d;
   logic [SIG_W-1:0]   y_q, y_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;

   logic                     a_sign, b_sign;
   logic [EXP_W-1:0]         a_exp, b_exp;
   logic [SIG_W-1:0]         a_sig, b_sig;
   logic [EXP_W+SIG_W-1:0]   a_mag, b_mag;

   // Unpack the operands. A zero exponent forces a zero significand.
   // The sign of b is flipped for subtraction.
   always_comb begin
      a_sign = bus.a[W-1];
      b_sign = bus.b[W-1] ^ bus.sub;
      a_exp  = bus.a[W-2:MAN_W];
      b_exp  = bus.b[W-2:MAN_W];
      a_sig  = (a_exp == '0) ? '0 : {2'b01, bus.a[MAN_W-1:0]};
      b_sig  = (b_exp == '0) ? '0 : {2'b01, bus.b[MAN_W-1:0]};
      a_mag  = {a_exp, a_sig};
      b_mag  = {b_exp, b_sig};
   end

   // State and datapath registers; clr wins over everything.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= IDLE;
         sign_q    <= 1'b0;
         eff_sub_q <= 1'b0;
         exp_q     <= '0;
         d_q       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         sum_q     <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         eff_sub_q <= eff_sub_d;
         exp_q     <= exp_d;
         d_q       <= d_d;
         x_q       <= x_d;
         y_q       <= y_d;
         sum_q     <= sum_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   // Next-state and datapath sequencing through capture, align, add and normalise.
   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      eff_sub_d = eff_sub_q;
      exp_d     = exp_q;
      d_d       = d_q;
      x_d       = x_q;
      y_d       = y_q;
      sum_d     = sum_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.go) begin
               state_d   = ALIGN;
               ovf_d     = 1'b0;
               unf_d     = 1'b0;
               eff_sub_d = a_sign ^ b_sign;
               if (a_mag >= b_mag) begin
                  sign_d = a_sign;
                  exp_d  = a_exp;
                  x_d    = a_sig;
                  y_d    = b_sig;
                  d_d    = a_exp - b_exp;
               end else begin
                  sign_d = b_sign;
                  exp_d  = b_exp;
                  x_d    = b_sig;
                  y_d    = a_sig;
                  d_d    = b_exp - a_exp;
               end
            end
         end
         ALIGN: begin
            if (d_q == '0) begin
               state_d = ADD;
            end else if (int'(d_q) > MAN_W + 1) begin
               y_d = '0;
               d_d = '0;
            end else begin
               y_d = y_q >> 1;
               d_d = d_q - EXP_W'(1);
            end
         end
         ADD: begin
            x_d     = eff_sub_q ? (x_q - y_q) : (x_q + y_q);
            state_d = NORM;
         end
         NORM: begin
            if (x_q == '0) begin
               sum_d   = '0;
               state_d = DONE;
            end else if (x_q[SIG_W-1]) begin
               if (exp_q == {EXP_W{1'b1}}) begin
                  sum_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                  ovf_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  x_d   = x_q >> 1;
                  exp_d = exp_q + EXP_W'(1);
               end
            end else if (!x_q[MAN_W]) begin
               if (exp_q == EXP_W'(1)) begin
                  sum_d   = '0;
                  unf_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  x_d   = x_q << 1;
                  exp_d = exp_q - EXP_W'(1);
               end
            end else begin
               sum_d   = {sign_q, exp_q, x_q[MAN_W-1:0]};
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Status outputs decoded from the state; the result and flags come straight from registers.
   always_comb begin
      bus.busy = (state_q == ALIGN) || (state_q == ADD) || (state_q == NORM);
      bus.done = (state_q == DONE);
      bus.sum  = sum_q;
      bus.ovf  = ovf_q;
      bus.unf  = unf_q;
   end
endmodule

// File: tb/tb_fpa_param.sv
// Directed testbench for fpa_param with the default widths (EXP_W=3, MAN_W=4, bias 3).
// A table of hand-computed vectors drives the main checks.
// Hand-written sequences cover reset, the handshake and clr mid-operation.
module tb_fpa_param;
   localparam int EXP_W   = 3;
   localparam int MAN_W   = 4;
   localparam int W       = 1 + EXP_W + MAN_W;
   localparam int MAX_LAT = 2 * MAN_W + 8;

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] sum;
      logic         ovf;
      logic         unf;
   } vec_t;

   logic clk = 1'b0;
   logic clr;
   int   checks   = 0;
   int   failures = 0;

   fpa_param_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

   fpa_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Pulse go with the given operands, then wait a bounded time for done.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int lat);
      @(negedge clk);
      bus.go  = 1'b1;
      bus.a   = a;
      bus.b   = b;
      bus.sub = s;
      @(negedge clk);
      bus.go = 1'b0;
      lat = 1;
      while (bus.done !== 1'b1 && lat <= MAX_LAT) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Main test sequence.
   initial begin
      vec_t vecs[$];
      int   lat;
      int   seen;

      vecs.push_back('{"add 6.5+1.5",      8'b0_101_1010, 8'b0_011_1000, 1'b0, 8'b0_110_0000, 1'b0, 1'b0});
      vecs.push_back('{"sub 6.5-1.5",      8'b0_101_1010, 8'b0_011_1000, 1'b1, 8'b0_101_0100, 1'b0, 1'b0});
      vecs.push_back('{"cancel to +0",     8'b0_100_0110, 8'b1_100_0110, 1'b0, 8'b0000_0000, 1'b0, 1'b0});
      vecs.push_back('{"overflow pos",     8'b0_111_1111, 8'b0_111_1111, 1'b0, 8'b0_111_1111, 1'b1, 1'b0});
      vecs.push_back('{"align loss",       8'b0_110_0000, 8'b0_001_0001, 1'b0, 8'b0_110_0000, 1'b0, 1'b0});
      vecs.push_back('{"underflow",        8'b0_001_0001, 8'b1_001_0000, 1'b0, 8'b0000_0000, 1'b0, 1'b1});
      vecs.push_back('{"neg result",       8'b0_011_1000, 8'b0_101_1010, 1'b1, 8'b1_101_0100, 1'b0, 1'b0});
      vecs.push_back('{"zero plus b",      8'b0_000_0000, 8'b0_011_1000, 1'b0, 8'b0_011_1000, 1'b0, 1'b0});
      vecs.push_back('{"exp0 reads zero",  8'b0_000_1111, 8'b0_010_0000, 1'b0, 8'b0_010_0000, 1'b0, 1'b0});
      vecs.push_back('{"multi left norm",  8'b0_110_0001, 8'b1_110_0000, 1'b0, 8'b0_010_0000, 1'b0, 1'b0});
      vecs.push_back('{"big shift zero",   8'b0_111_0000, 8'b0_001_1111, 1'b0, 8'b0_111_0000, 1'b0, 1'b0});
      vecs.push_back('{"neg cancel +0",    8'b1_010_1000, 8'b1_010_1000, 1'b1, 8'b0000_0000, 1'b0, 1'b0});
      vecs.push_back('{"neg plus neg",     8'b1_010_0000, 8'b1_010_0000, 1'b0, 8'b1_011_0000, 1'b0, 1'b0});
      vecs.push_back('{"overflow neg",     8'b1_111_1000, 8'b0_111_1000, 1'b1, 8'b1_111_1111, 1'b1, 1'b0});
      vecs.push_back('{"truncation",       8'b0_011_0001, 8'b0_010_0001, 1'b0, 8'b0_011_1001, 1'b0, 1'b0});

      bus.go  = 1'b0;
      bus.sub = 1'b0;
      bus.a   = '0;
      bus.b   = '0;
      clr     = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset done", 32'(bus.done), 32'd0);
      checkOutput("reset sum",  32'(bus.sum),  32'd0);
      checkOutput("reset ovf",  32'(bus.ovf),  32'd0);
      checkOutput("reset unf",  32'(bus.unf),  32'd0);
      clr = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
         checkOutput({vecs[i].name, " done"},    32'(bus.done), 32'd1);
         checkOutput({vecs[i].name, " latency"}, 32'(lat <= MAX_LAT), 32'd1);
         checkOutput({vecs[i].name, " sum"},     32'(bus.sum), 32'(vecs[i].sum));
         checkOutput({vecs[i].name, " ovf"},     32'(bus.ovf), 32'(vecs[i].ovf));
         checkOutput({vecs[i].name, " unf"},     32'(bus.unf), 32'(vecs[i].unf));
      end

      // done and the result hold while idle in DONE.
      repeat (3) @(negedge clk);
      checkOutput("done held", 32'(bus.done), 32'd1);
      checkOutput("sum held",  32'(bus.sum),  32'(8'b0_011_1001));

      // A new go from DONE drops done next cycle, and a go while busy is ignored.
      bus.go  = 1'b1;
      bus.a   = 8'b0_101_1010;
      bus.b   = 8'b0_011_1000;
      bus.sub = 1'b0;
      @(negedge clk);
      bus.go = 1'b0;
      checkOutput("done drops", 32'(bus.done), 32'd0);
      checkOutput("busy rises", 32'(bus.busy), 32'd1);
      bus.go = 1'b1;
      bus.a  = 8'b0_111_1111;
      bus.b  = 8'b0_111_1111;
      @(negedge clk);
      bus.go = 1'b0;
      lat = 2;
      while (bus.done !== 1'b1 && lat <= MAX_LAT) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("busy go done",   32'(bus.done), 32'd1);
      checkOutput("busy go ignored", 32'(bus.sum), 32'(8'b0_110_0000));
      checkOutput("busy go ovf",    32'(bus.ovf),  32'd0);

      // clr during ALIGN abandons the operation and nothing completes afterwards.
      bus.go  = 1'b1;
      bus.a   = 8'b0_101_1010;
      bus.b   = 8'b0_011_1000;
      bus.sub = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
      clr    = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      checkOutput("clr busy", 32'(bus.busy), 32'd0);
      checkOutput("clr done", 32'(bus.done), 32'd0);
      checkOutput("clr sum",  32'(bus.sum),  32'd0);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen++;
      end
      checkOutput("no done after clr", 32'(seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
